shifter_seq: RTL and testbench

SHIFTER_SEQ -- requirements
Module: shifter_seq

---
 rtl/shifter_seq.sv | 121 ++++++++++++
 tb/tb_shifter_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shifter_seq.sv
// shifter_seq: sequential barrel-shifter replacement. It shifts one bit per
// cycle through a three-state FSM (IDLE -> SHIFT -> DONE) with valid/ready
// handshakes on both sides.
// Optional feature macro: SHIFTER_ROTATE_EN. When it is defined, F=4/5
// perform ROL/ROR. When it is undefined, those codes pass A through.
module shifter_seq #(
  parameter int N = 4,
  localparam int W = 1 << N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [N-1:0] Sh,
  input  logic [2:0]   F,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Y,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0]   OP_SLL  = 3'd0;
  localparam logic [2:0]   OP_SRL  = 3'd1;
  localparam logic [2:0]   OP_SRA  = 3'd3;
`ifdef SHIFTER_ROTATE_EN
  localparam logic [2:0]   OP_ROL  = 3'd4;
  localparam logic [2:0]   OP_ROR  = 3'd5;
`endif
  localparam logic [N-1:0] CNT_ONE = N'(1);

  state_t         state_reg, state_next;
  logic [W-1:0]   work_reg, work_next;
  logic [N-1:0]   cnt_reg, cnt_next;
  logic [2:0]     mode_reg, mode_next;
  logic           is_shift_op;
  logic [W-1:0]   step_val;

  // Decode which opcodes need SHIFT cycles; every other code completes as PASS.
  always_comb begin
    is_shift_op = 1'b0;
    case (F)
      OP_SLL, OP_SRL, OP_SRA: is_shift_op = 1'b1;
`ifdef SHIFTER_ROTATE_EN
      OP_ROL, OP_ROR:         is_shift_op = 1'b1;
`endif
      default:                is_shift_op = 1'b0;
    endcase
  end

  // Compute one single-bit step of the latched operation on the working register.
  always_comb begin
    step_val = work_reg;
    case (mode_reg)
      OP_SLL: step_val = {work_reg[W-2:0], 1'b0};
      OP_SRL: step_val = {1'b0, work_reg[W-1:1]};
      OP_SRA: step_val = {work_reg[W-1], work_reg[W-1:1]};
`ifdef SHIFTER_ROTATE_EN
      OP_ROL: step_val = {work_reg[W-2:0], work_reg[W-1]};
      OP_ROR: step_val = {work_reg[0], work_reg[W-1:1]};
`endif
      default: step_val = work_reg;
    endcase
  end

  // Compute the next-state and datapath updates for the FSM.
  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          work_next = A;
          cnt_next  = Sh;
          mode_next = F;
          if (is_shift_op && (Sh != '0)) state_next = SHIFT;
          else                           state_next = DONE;
        end
      end
      SHIFT: begin
        work_next = step_val;
        cnt_next  = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) state_next = DONE;
      end
      DONE: begin
        // Returning to IDLE forces at least one idle cycle between results.
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Hold the state, working register, counter and mode. Reset clears them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
      mode_reg  <= '0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == SHIFT);
  assign Y         = work_reg;

endmodule

// File: tb/tb_shifter_seq.sv
// tb_shifter_seq: table vectors, hand-written corner sequences and a random
// run of back-to-back requests. Each result is checked against an arithmetic
// reference model.
module tb_shifter_seq;
  localparam int N = 4;
  localparam int W = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [N-1:0] Sh = '0;
  logic [2:0]   F = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Y;
  logic         busy;

  int checks = 0;
  int failures = 0;

  shifter_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .Sh(Sh), .F(F), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [N-1:0] sh;
    logic [2:0]   f;
    logic [W-1:0] y;
    int           lat;
  } vec_t;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic bit is_pass(input logic [2:0] f);
`ifdef SHIFTER_ROTATE_EN
    return !(f inside {3'd0, 3'd1, 3'd3, 3'd4, 3'd5});
`else
    return !(f inside {3'd0, 3'd1, 3'd3});
`endif
  endfunction

  // Reference: whole-word operators, not one-bit steps.
  function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, input int sh, input logic [2:0] f);
    logic [2*W-1:0] dbl;
    dbl = {a, a};
    if (is_pass(f)) return a;
    case (f)
      3'd0: return a << sh;
      3'd1: return a >> sh;
      3'd3: return W'($signed(a) >>> sh);
      3'd4: return dbl[2*W-1-sh -: W];
      3'd5: return dbl[sh +: W];
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(input int sh, input logic [2:0] f);
    return (is_pass(f) || sh == 0) ? 1 : sh + 1;
  endfunction

  // Issue one request starting at a negedge. Return the result and the latency
  // counted in edges from the accept edge to the edge that samples out_valid.
  // hold < 0 gives a random out_ready pattern; otherwise out_ready is held low
  // for that many cycles before the result is consumed.
  task automatic do_req(input logic [W-1:0] a, input logic [N-1:0] sh, input logic [2:0] f,
                        input int hold, output logic [W-1:0] y, output int lat);
    int guard;
    int h;
    A = a; Sh = sh; F = f; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = W'($urandom); Sh = N'($urandom); F = 3'($urandom);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("busy_or_wait_ready", {31'd0, in_ready}, 0);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    y = Y;
    h = (hold < 0) ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0) : hold;
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      check("hold_y_stable", Y, y);
      check("hold_out_valid", {31'd0, out_valid}, 1);
      check("hold_in_ready", {31'd0, in_ready}, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t tbl[11];
  logic [W-1:0] y;
  int lat;
  bit seen;

  initial begin
    tbl[0]  = '{16'h00B6, 4'd4,  3'd0, 16'h0B60, 5};
    tbl[1]  = '{16'h8000, 4'd3,  3'd3, 16'hF000, 4};
    tbl[2]  = '{16'h8000, 4'd3,  3'd1, 16'h1000, 4};
`ifdef SHIFTER_ROTATE_EN
    tbl[3]  = '{16'h0001, 4'd1,  3'd5, 16'h8000, 2};
    tbl[9]  = '{16'h8001, 4'd4,  3'd4, 16'h0018, 5};
`else
    tbl[3]  = '{16'h0001, 4'd1,  3'd5, 16'h0001, 1};
    tbl[9]  = '{16'h8001, 4'd4,  3'd4, 16'h8001, 1};
`endif
    tbl[4]  = '{16'h1234, 4'd0,  3'd0, 16'h1234, 1};
    tbl[5]  = '{16'h7FFF, 4'd15, 3'd0, 16'h8000, 16};
    tbl[6]  = '{16'h7FF0, 4'd4,  3'd3, 16'h07FF, 5};
    tbl[7]  = '{16'hABCD, 4'd5,  3'd2, 16'hABCD, 1};
    tbl[8]  = '{16'hABCD, 4'd5,  3'd7, 16'hABCD, 1};
    tbl[10] = '{16'h1234, 4'd15, 3'd1, 16'h0000, 16};

    // Reset state, checked while reset is held.
    #12;
    check("rst_y", Y, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors. The first one also exercises acceptance at the first edge after reset.
    foreach (tbl[i]) begin
      do_req(tbl[i].a, tbl[i].sh, tbl[i].f, 0, y, lat);
      $display("vec %0d: A=%h Sh=%0d F=%0d -> Y=%h lat=%0d", i, tbl[i].a, tbl[i].sh, tbl[i].f, y, lat);
      check($sformatf("vec%0d_y", i), y, tbl[i].y);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
    end

    // Sh=0 result held for five cycles with out_ready low.
    do_req(16'h1234, 4'd0, 3'd0, 5, y, lat);
    $display("hold: Y=%h lat=%0d", y, lat);
    check("hold_seq_y", y, 16'h1234);
    check("hold_seq_lat", lat, 1);

    // Asynchronous reset in the middle of a long shift.
    A = 16'hFFFF; Sh = 4'd15; F = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("midshift_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_y", Y, 0);
    check("async_rst_out_valid", {31'd0, out_valid}, 0);
    check("async_rst_busy", {31'd0, busy}, 0);
    check("async_rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    $display("reset abort: stray activity=%0d", seen);
    check("no_result_after_reset", {31'd0, seen}, 0);

    // Random back-to-back requests with random out_ready stalls.
    for (int n = 0; n < 2000; n++) begin
      logic [W-1:0] ra;
      logic [N-1:0] rs;
      logic [2:0]   rf;
      ra = W'($urandom);
      rs = N'($urandom);
      rf = 3'($urandom);
      do_req(ra, rs, rf, -1, y, lat);
      $display("rnd %0d: A=%h Sh=%0d F=%0d -> Y=%h lat=%0d", n, ra, rs, rf, y, lat);
      check("rnd_y", y, ref_y(ra, int'(rs), rf));
      check("rnd_lat", lat, ref_lat(int'(rs), rf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
